// File: rtl/fact_responder_pkg.sv
// fact_responder_pkg
//   Shared definitions for the factorial responder: bus word addresses,
//   FSM state encoding and the default largest legal operand.
package fact_responder_pkg;

  // Largest N whose factorial still fits in 32 bits (12! = 479001600).
  localparam int unsigned N_MAX_DEFAULT = 12;

  // Word addresses (bus address bits 3:2).
  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MULT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fact_responder_dp.sv
// fact_dp
//   Factorial datapath: down-counter cnt and running product prod.
//   Ports:
//     clk      - clock, rising edge
//     srst     - synchronous active-high reset, clears cnt and prod
//     load     - cnt <= n_in, prod <= 1
//     step     - one multiply iteration when cnt > 1 (hold otherwise)
//     n_in     - operand captured on load
//     cnt_le1  - cnt <= 1, i.e. the product is final
//     prod     - current running product
module fact_dp
  import fact_responder_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        load,
  input  logic        step,
  input  logic [3:0]  n_in,
  output logic        cnt_le1,
  output logic [31:0] prod
);

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] prod_q, prod_d;

  assign cnt_le1 = (cnt_q <= 4'd1);
  assign prod    = prod_q;

  always_comb begin
    cnt_d  = cnt_q;
    prod_d = prod_q;
    if (load) begin
      cnt_d  = n_in;
      prod_d = 32'd1;
    end else if (step && !cnt_le1) begin
      // Only the low 32 bits are kept; legal operands never overflow.
      prod_d = prod_q * {28'd0, cnt_q};
      cnt_d  = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q  <= 4'd0;
      prod_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

endmodule

// File: rtl/fact_responder.sv
// fact_responder
//   Bus-mapped factorial engine. Software writes N, writes Go, polls STATUS
//   and reads RESULT. Holds the control FSM, the register file and the read
//   mux; the iteration itself lives in fact_dp.
//   Ports:
//     Clk  - clock, rising edge
//     Rst  - synchronous active-high reset (wins over a same-cycle write)
//     A    - word address: 0 N, 1 CTRL, 2 STATUS, 3 RESULT
//     WE   - write enable
//     WD   - write data
//     RD   - combinational read data for address A
//     Busy - computation in progress (LOAD or MULT)
module fact_responder
  import fact_responder_pkg::*;
#(
  parameter int unsigned N_MAX = N_MAX_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  A,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Busy
);

  localparam logic [3:0] N_MAX_W = 4'(N_MAX);

  state_t      state_q, state_d;
  logic [3:0]  n_q, n_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] result_q, result_d;

  logic        go;
  logic        dp_load;
  logic        dp_step;
  logic        dp_cnt_le1;
  logic [31:0] dp_prod;

  // Upper write-data bits carry nothing for this register map.
  logic unused_wd;
  assign unused_wd = ^WD[31:4];

  assign go   = WE && (A == ADDR_CTRL) && WD[0];
  assign Busy = (state_q == ST_LOAD) || (state_q == ST_MULT);

  fact_dp u_dp (
    .clk     (Clk),
    .srst    (Rst),
    .load    (dp_load),
    .step    (dp_step),
    .n_in    (n_q),
    .cnt_le1 (dp_cnt_le1),
    .prod    (dp_prod)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    done_d   = done_q;
    err_d    = err_q;
    result_d = result_q;
    dp_load  = 1'b0;
    dp_step  = 1'b0;

    // N is writable in every state; a running job already copied it into cnt.
    if (WE && (A == ADDR_N)) begin
      n_d = WD[3:0];
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          state_d = ST_LOAD;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        // cnt/prod are loaded even on error; they are simply never used.
        dp_load = 1'b1;
        if (n_q > N_MAX_W) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          err_d    = 1'b1;
          result_d = 32'd0;
        end else begin
          state_d = ST_MULT;
        end
      end
      ST_MULT: begin
        dp_step = 1'b1;
        if (dp_cnt_le1) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = dp_prod;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      n_q      <= 4'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    RD = 32'd0;
    case (A)
      ADDR_N:      RD = {28'd0, n_q};
      ADDR_CTRL:   RD = 32'd0;
      ADDR_STATUS: RD = {30'd0, err_q, done_q};
      ADDR_RESULT: RD = result_q;
      default:     RD = 32'd0;
    endcase
  end

endmodule
